// File: rtl/soc_evt_pkg.sv
// soc_evt_pkg: shared SoC event type and buffer sizing
package soc_evt_pkg;
  localparam int SOC_EVT_WIDTH = 8;
  localparam int SOC_EVT_FIFO_DEPTH = 8;
  typedef logic [SOC_EVT_WIDTH-1:0] soc_evt_t;
endpackage

// File: rtl/soc_evt_fifo.sv
// soc_evt_fifo: generic synchronous flop-array FIFO with wrap-bit pointers
module soc_evt_fifo
  import soc_evt_pkg::*;
#(
  parameter int WIDTH = SOC_EVT_WIDTH,
  parameter int DEPTH = SOC_EVT_FIFO_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= data_in;
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end
  assign data_out = mem[rd_ptr[AW-1:0]];
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign level = wr_ptr - rd_ptr;
endmodule

// File: rtl/soc_evt_buffer.sv
// soc_evt_buffer: non-stalling SoC event FIFO with drop counting toward the event unit
module soc_evt_buffer
  import soc_evt_pkg::*;
#(
  parameter int EVNT_WIDTH = SOC_EVT_WIDTH,
  parameter int DEPTH = SOC_EVT_FIFO_DEPTH,
  parameter int CNT_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     evt_valid_i,
  input  logic [EVNT_WIDTH-1:0]    evt_data_i,
  output logic                     evt_valid_o,
  output logic [EVNT_WIDTH-1:0]    evt_data_o,
  input  logic                     evt_ready_i,
  input  logic                     clr_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o,
  output logic [CNT_WIDTH-1:0]     drop_cnt_o
);
  logic full, empty, push, pop, drop;
  assign evt_valid_o = !empty;
  assign pop = evt_valid_o && evt_ready_i;
  assign push = evt_valid_i && (!full || pop);
  assign drop = evt_valid_i && full && !pop;
  soc_evt_fifo #(.WIDTH(EVNT_WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(clk_i),
    .rst(rst_i),
    .push(push),
    .pop(pop),
    .data_in(evt_data_i),
    .data_out(evt_data_o),
    .full(full),
    .empty(empty),
    .level(level_o)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drop_cnt_o <= '0;
      overflow_o <= 1'b0;
    end else if (drop) begin
      drop_cnt_o <= clr_i ? CNT_WIDTH'(1) : (&drop_cnt_o) ? drop_cnt_o : drop_cnt_o + CNT_WIDTH'(1);
      overflow_o <= 1'b1;
    end else if (clr_i) begin
      drop_cnt_o <= '0;
      overflow_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_soc_evt_buffer.sv
// tb_soc_evt_buffer: directed self-checking bench for soc_evt_buffer
module tb_soc_evt_buffer;
  import soc_evt_pkg::*;
  logic clk = 1'b0, rst = 1'b1, evt_valid_i = 1'b0, evt_ready_i = 1'b0, clr_i = 1'b0;
  soc_evt_t evt_data_i = '0;
  logic evt_valid_o, overflow_o, s_valid, s_ovf;
  soc_evt_t evt_data_o, s_data;
  logic [3:0] level_o, s_level, s_cnt;
  logic [15:0] drop_cnt_o;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  soc_evt_buffer u_dut (
    .clk_i(clk), .rst_i(rst), .evt_valid_i(evt_valid_i), .evt_data_i(evt_data_i),
    .evt_valid_o(evt_valid_o), .evt_data_o(evt_data_o), .evt_ready_i(evt_ready_i),
    .clr_i(clr_i), .level_o(level_o), .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o)
  );
  soc_evt_buffer #(.CNT_WIDTH(4)) u_sat (
    .clk_i(clk), .rst_i(rst), .evt_valid_i(evt_valid_i), .evt_data_i(evt_data_i),
    .evt_valid_o(s_valid), .evt_data_o(s_data), .evt_ready_i(evt_ready_i),
    .clr_i(clr_i), .level_o(s_level), .overflow_o(s_ovf), .drop_cnt_o(s_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input soc_evt_t d);
    evt_valid_i = 1'b1;
    evt_data_i = d;
    cyc();
    evt_valid_i = 1'b0;
  endtask
  initial begin
    soc_evt_t q[$];
    soc_evt_t exp3[8];
    soc_evt_t prev_data;
    logic prev_hold, pop_now;
    int drops, n;
    cyc();
    cyc();
    rst = 1'b0;
    chk("rst_valid", evt_valid_o, 0);
    chk("rst_data", evt_data_o, 0);
    chk("rst_level", level_o, 0);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_cnt", drop_cnt_o, 0);
    evt_ready_i = 1'b1;
    evt_valid_i = 1'b1;
    evt_data_i = 8'h2A;
    #1;
    chk("no_bypass", evt_valid_o, 0);
    cyc();
    evt_valid_i = 1'b0;
    chk("single_valid", evt_valid_o, 1);
    chk("single_data", evt_data_o, 8'h2A);
    chk("single_level", level_o, 1);
    cyc();
    chk("single_popped", evt_valid_o, 0);
    chk("single_level0", level_o, 0);
    evt_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) push(soc_evt_t'(i));
    chk("fill_level", level_o, 8);
    chk("fill_cnt", drop_cnt_o, 2);
    chk("fill_ovf", overflow_o, 1);
    chk("fill_head", evt_data_o, 8'h00);
    evt_ready_i = 1'b1;
    push(8'h55);
    chk("fullpp_level", level_o, 8);
    chk("fullpp_cnt", drop_cnt_o, 2);
    chk("fullpp_head", evt_data_o, 8'h01);
    exp3 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h55};
    for (int i = 0; i < 8; i++) begin
      chk("drain_valid", evt_valid_o, 1);
      chk("drain_data", evt_data_o, exp3[i]);
      cyc();
    end
    chk("drain_level", level_o, 0);
    chk("drain_empty", evt_valid_o, 0);
    clr_i = 1'b1;
    cyc();
    clr_i = 1'b0;
    chk("clr_cnt", drop_cnt_o, 0);
    chk("clr_ovf", overflow_o, 0);
    drops = 0;
    prev_hold = 1'b0;
    prev_data = '0;
    for (int i = 0; i < 16; i++) begin
      evt_valid_i = 1'b1;
      evt_data_i = soc_evt_t'(8'h10 + i);
      evt_ready_i = 1'($urandom_range(0, 1));
      #1;
      chk("bp_valid", evt_valid_o, q.size() != 0);
      if (prev_hold) chk("bp_stable", evt_data_o, prev_data);
      pop_now = q.size() != 0 && evt_ready_i;
      if (pop_now) begin
        chk("bp_order", evt_data_o, q[0]);
        void'(q.pop_front());
      end
      prev_hold = q.size() != 0 && !pop_now && !evt_ready_i;
      prev_data = evt_data_o;
      if (q.size() < 8) q.push_back(evt_data_i);
      else drops++;
      cyc();
    end
    evt_valid_i = 1'b0;
    evt_ready_i = 1'b1;
    n = 0;
    while (q.size() > 0 && n < 20) begin
      chk("bp_tail_valid", evt_valid_o, 1);
      chk("bp_tail_data", evt_data_o, q[0]);
      void'(q.pop_front());
      cyc();
      n++;
    end
    chk("bp_timeout", q.size(), 0);
    chk("bp_level", level_o, 0);
    chk("bp_drops", drop_cnt_o, drops);
    clr_i = 1'b1;
    cyc();
    clr_i = 1'b0;
    evt_ready_i = 1'b0;
    for (int i = 0; i < 28; i++) push(soc_evt_t'(8'h40 + i));
    chk("sat_cnt16", drop_cnt_o, 20);
    chk("sat_cnt4", s_cnt, 15);
    chk("sat_ovf", s_ovf, 1);
    chk("sat_level", s_level, 8);
    clr_i = 1'b1;
    evt_valid_i = 1'b1;
    cyc();
    clr_i = 1'b0;
    evt_valid_i = 1'b0;
    chk("clrdrop_cnt4", s_cnt, 1);
    chk("clrdrop_cnt16", drop_cnt_o, 1);
    chk("clrdrop_ovf", overflow_o, 1);
    chk("clrdrop_keep", s_data, 8'h40);
    evt_ready_i = 1'b1;
    repeat (8) cyc();
    chk("sat_drained", level_o, 0);
    evt_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) push(soc_evt_t'(8'h60 + i));
    chk("pre_rst_level", level_o, 5);
    rst = 1'b1;
    evt_valid_i = 1'b1;
    evt_data_i = 8'h77;
    cyc();
    rst = 1'b0;
    evt_valid_i = 1'b0;
    chk("midrst_valid", evt_valid_o, 0);
    chk("midrst_level", level_o, 0);
    chk("midrst_cnt", drop_cnt_o, 0);
    chk("midrst_ovf", overflow_o, 0);
    chk("midrst_data", evt_data_o, 0);
    evt_ready_i = 1'b1;
    push(8'h3C);
    chk("post_rst_valid", evt_valid_o, 1);
    chk("post_rst_data", evt_data_o, 8'h3C);
    cyc();
    chk("post_rst_level", level_o, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
